// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM read-modify-write controller.
//   ram_ctrl_state_t : controller FSM states (INIT only reachable when
//                      RAM_RMW_CTRL_CLEAR_EN is defined)
//   BYTE_W           : width of one byte lane
package ram_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RESP = 2'd2,
    INIT = 2'd3
  } ram_ctrl_state_t;

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational per-byte merge of a new word into an old word.
// Ports:
//   old_word in  M     current RAM word
//   new_word in  M     write data
//   be       in  M/8   byte enables; be[i] selects new_word byte i
//   merged   out M     be[i] ? new byte : old byte, for every lane
module ram_byte_merge
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned M = 32
) (
  input  logic [M-1:0]        old_word,
  input  logic [M-1:0]        new_word,
  input  logic [M/BYTE_W-1:0] be,
  output logic [M-1:0]        merged
);

  localparam int unsigned NB = M / BYTE_W;

  always_comb begin
    merged = old_word;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) begin
        merged[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/ram_rmw_ctrl.sv
// Request/response front end for a single-port sync-write/async-read RAM.
// One read or byte-masked write outstanding at a time; partial writes are
// done as read-modify-write so the RAM only needs a word write port.
// Optional feature macro: RAM_RMW_CTRL_CLEAR_EN (zero-fill sweep after reset).
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we, req_adr, req_be,
//   req_wdata                     request payload (be/wdata used by writes)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata                     read word, or merged word after a write
//   ram_we, ram_adr, ram_din      to the RAM
//   ram_dout                      from the RAM, combinational read
module ram_rmw_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned N = 6,
  parameter int unsigned M = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [N-1:0]        req_adr,
  input  logic [M/BYTE_W-1:0] req_be,
  input  logic [M-1:0]        req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [M-1:0]        rsp_rdata,
  output logic                ram_we,
  output logic [N-1:0]        ram_adr,
  output logic [M-1:0]        ram_din,
  input  logic [M-1:0]        ram_dout
);

  localparam int unsigned NB = M / BYTE_W;

  ram_ctrl_state_t state, state_nx;
  logic [N-1:0]    adr_q;
  logic [NB-1:0]   be_q;
  logic [M-1:0]    wdata_q;
  logic [M-1:0]    merged;
`ifdef RAM_RMW_CTRL_CLEAR_EN
  logic [N-1:0]    cnt;
`endif

  // In WR the RAM address is the latched one, so ram_dout is the old word.
  ram_byte_merge #(.M(M)) u_merge (
    .old_word (ram_dout),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef RAM_RMW_CTRL_CLEAR_EN
      state <= INIT;
      cnt   <= '0;
`else
      state <= IDLE;
`endif
      rsp_rdata <= '0;
      adr_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_we) begin
              adr_q   <= req_adr;
              be_q    <= req_be;
              wdata_q <= req_wdata;
            end else begin
              rsp_rdata <= ram_dout;
            end
          end
        end
        WR: rsp_rdata <= merged;
`ifdef RAM_RMW_CTRL_CLEAR_EN
        INIT: cnt <= cnt + N'(1);
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_we    = 1'b0;
    ram_adr   = req_adr;
    ram_din   = merged;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_we ? WR : RESP;
      end
      WR: begin
        ram_adr  = adr_q;
        ram_we   = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
`ifdef RAM_RMW_CTRL_CLEAR_EN
      INIT: begin
        ram_adr = cnt;
        ram_we  = 1'b1;
        ram_din = '0;
        if (cnt == '1) state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
    // Reset overrides the state decode so an in-flight WR never reaches the RAM.
    if (reset) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      ram_we    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Self-checking bench for ram_rmw_ctrl with a behavioural RAM attached.
// Honours RAM_RMW_CTRL_CLEAR_EN when it is defined for the build.
module tb_ram_rmw_ctrl;

  localparam int N     = 6;
  localparam int M     = 32;
  localparam int NB    = M / 8;
  localparam int DEPTH = 1 << N;
`ifdef RAM_RMW_CTRL_CLEAR_EN
  localparam bit CLEAR = 1'b1;
`else
  localparam bit CLEAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [N-1:0]  req_adr = '0;
  logic [NB-1:0] req_be = '0;
  logic [M-1:0]  req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [M-1:0]  rsp_rdata;
  logic          ram_we;
  logic [N-1:0]  ram_adr;
  logic [M-1:0]  ram_din;
  logic [M-1:0]  ram_dout;

  int total = 0;
  int bad   = 0;

  ram_rmw_ctrl #(.N(N), .M(M)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_adr   (ram_adr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] seed(input int i);
    return (i == 3) ? '0 : (32'h1000_0000 + 32'(i) * 32'h0000_0101);
  endfunction

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural RAM (sync write, async read), seeded on the first edge.
  logic [M-1:0] ram [DEPTH];
  bit ram_seeded = 1'b0;
  assign ram_dout = ram[ram_adr];
  always @(posedge clk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= seed(i);
      ram_seeded <= 1'b1;
    end else if (ram_we) begin
      ram[ram_adr] <= ram_din;
    end
  end

  // Transaction-level model: memory contents plus "one request in flight,
  // response due after 0 (read) or 1 (write) extra cycles".
  logic [M-1:0] mem [DEPTH];
  bit           m_seeded = 1'b0;
  bit           m_known = 1'b0;
  bit           busy = 1'b0;
  int           wait_c = 0;
  int           init_left = 0;
  bit           pend_wr = 1'b0;
  logic [N-1:0] pend_adr;
  logic [M-1:0] exp_data = '0;

  always @(posedge clk) begin
    logic [M-1:0] w;
    if (!m_seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = seed(i);
      m_seeded = 1'b1;
    end
    if (reset) begin
      m_known   = 1'b1;
      busy      = 1'b0;
      pend_wr   = 1'b0;
      wait_c    = 0;
      init_left = CLEAR ? DEPTH : 0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else if (busy) begin
      if (wait_c > 0) begin
        wait_c--;
        if (pend_wr) mem[pend_adr] = exp_data;
        pend_wr = 1'b0;
      end else if (rsp_ready) begin
        busy = 1'b0;
      end
    end else if (req_valid) begin
      busy = 1'b1;
      if (req_we) begin
        w = mem[req_adr];
        for (int b = 0; b < NB; b++)
          if (req_be[b]) w[b*8 +: 8] = req_wdata[b*8 +: 8];
        exp_data = w;
        pend_adr = req_adr;
        pend_wr  = 1'b1;
        wait_c   = 1;
      end else begin
        exp_data = mem[req_adr];
        wait_c   = 0;
      end
    end
  end

  int we_pulses = 0;

  // Compare process: every cycle, 1 time unit after the falling edge.
  always @(negedge clk) begin
    #1;
    if (ram_we === 1'b1) we_pulses++;
    if (reset) begin
      chk("rst_req_ready", M'(req_ready), '0);
      chk("rst_rsp_valid", M'(rsp_valid), '0);
      chk("rst_ram_we", M'(ram_we), '0);
    end else if (m_known) begin
      chk("req_ready", M'(req_ready), M'(!busy && init_left == 0));
      chk("rsp_valid", M'(rsp_valid), M'(busy && wait_c == 0));
      chk("ram_we", M'(ram_we), M'(init_left > 0 || (busy && wait_c > 0)));
      if (busy && wait_c == 0) chk("rsp_rdata", rsp_rdata, exp_data);
    end
  end

  task automatic do_req(input bit we, input logic [N-1:0] adr, input logic [NB-1:0] be,
                        input logic [M-1:0] wdata, input int hold,
                        output logic [M-1:0] data, output int lat, output int pulses);
    int budget;
    int p0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_be    = be;
    req_wdata = wdata;
    p0        = we_pulses;
    budget    = 0;
    #1;
    while (!req_ready && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!req_ready) chk("accept_timeout", M'(req_ready), M'(1));
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    #1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", M'(rsp_valid), M'(1));
    data = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", M'(rsp_valid), M'(1));
      chk("bp_rdata", rsp_rdata, data);
      chk("bp_ready", M'(req_ready), '0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("single_hs", M'(rsp_valid), '0);
    pulses = we_pulses - p0;
  endtask

  initial begin
    logic [M-1:0] d;
    int lat;
    int pl;
    int cnt;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_rdata", rsp_rdata, '0);
    @(negedge clk);
    reset = 1'b0;

`ifdef RAM_RMW_CTRL_CLEAR_EN
    // Abort the sweep at count 20, then time a complete one.
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    #1;
    while (!req_ready && cnt < 200) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    chk("init_cycles", M'(cnt), M'(64));
    do_req(1'b0, 6'd0, '0, '0, 0, d, lat, pl);
    chk("init_adr0", d, '0);
    do_req(1'b0, 6'd63, '0, '0, 0, d, lat, pl);
    chk("init_adr63", d, '0);
`else
    cnt = 0;
`endif

    // Full write then read-back.
    do_req(1'b1, 6'd5, 4'hF, 32'hDEADBEEF, 0, d, lat, pl);
    chk("t1_wr_data", d, 32'hDEADBEEF);
    chk("t1_wr_lat", M'(lat), M'(2));
    do_req(1'b0, 6'd5, '0, '0, 0, d, lat, pl);
    chk("t1_rd_data", d, 32'hDEADBEEF);
    chk("t1_rd_lat", M'(lat), M'(1));

    // Partial write merges bytes 0 and 2.
    do_req(1'b1, 6'd5, 4'b0101, 32'h11223344, 0, d, lat, pl);
    chk("t2_wr_data", d, 32'hDE22BE44);
    do_req(1'b0, 6'd5, '0, '0, 0, d, lat, pl);
    chk("t2_rd_data", d, 32'hDE22BE44);

    // Response backpressure for 5 cycles.
    do_req(1'b0, 6'd5, '0, '0, 5, d, lat, pl);
    chk("t3_rd_data", d, 32'hDE22BE44);

    // be==0 write still pulses ram_we once and leaves the word alone.
    do_req(1'b1, 6'd7, 4'hF, 32'hA5A5A5A5, 0, d, lat, pl);
    do_req(1'b1, 6'd7, 4'h0, 32'h12345678, 0, d, lat, pl);
    chk("t4_wr_data", d, 32'hA5A5A5A5);
    chk("t4_we_pulses", M'(pl), M'(1));
    do_req(1'b0, 6'd7, '0, '0, 0, d, lat, pl);
    chk("t4_rd_data", d, 32'hA5A5A5A5);

    // Top address with a single-lane write.
    do_req(1'b1, 6'd63, 4'b1000, 32'hAB000000, 0, d, lat, pl);
    do_req(1'b0, 6'd63, '0, '0, 0, d, lat, pl);
    chk("top_adr_byte3", M'(d[31:24]), M'(8'hAB));

    // Reset lands on the WR cycle of a write to adr 3.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_adr   = 6'd3;
    req_be    = 4'hF;
    req_wdata = 32'hFFFFFFFF;
    #1;
    chk("t5_ready", M'(req_ready), M'(1));
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    chk("t5_we_in_reset", M'(ram_we), '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_no_rsp", M'(rsp_valid), '0);
    do_req(1'b0, 6'd3, '0, '0, 0, d, lat, pl);
    chk("t5_rd_data", d, '0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
